// File: rtl/router_out_drain_if.sv
// rtl/router_out_drain_if.sv - output byte stream between the drain stage and its sink
interface router_out_drain_if;
   logic [7:0] m_data;
   logic       m_valid;
   logic       m_ready;
   logic       m_sop;
   logic       m_eop;

   modport master (output m_data, output m_valid, output m_sop, output m_eop, input m_ready);
   modport slave  (input m_data, input m_valid, input m_sop, input m_eop, output m_ready);
endinterface

// File: rtl/router_out_drain.sv
// rtl/router_out_drain.sv - router output port drain: framing parse, parity/addr check, 2-entry stream buffer
// Optional DRAIN_PARITY_STRIP_EN: parity byte is checked but not forwarded; eop moves to the last data beat.
module router_out_drain #(
   parameter int PORT_ID   = 0,
   parameter int STALL_MAX = 63,
   parameter int CNT_W     = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             vld_out,
   input  logic [7:0]       dout,
   output logic             read_enb,
   router_out_drain_if.master m_if,
   output logic             pkt_done,
   output logic             pkt_err,
   output logic             addr_err,
   output logic             abort,
   output logic [CNT_W-1:0] pkt_count,
   output logic [CNT_W-1:0] err_count
);

`ifdef DRAIN_PARITY_STRIP_EN
   localparam bit STRIP = 1'b1;
`else
   localparam bit STRIP = 1'b0;
`endif
   localparam int SW = $clog2(STALL_MAX + 1);

   typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, PARITY, DONE} state_t;

   state_t        state;
   logic          inflight;
   logic [1:0]    occ;
   logic          rd_ptr, wr_ptr;
   logic [9:0]    buf_q [2];
   logic [7:0]    acc;
   logic [5:0]    rem;
   logic [6:0]    reads_left;
   logic [1:0]    hdr_addr;
   logic [SW-1:0] stall_cnt;

   logic       pop, push, push_sop, push_eop, owed, aerr_w;
   logic [2:0] credit_use;

   assign m_if.m_valid = (occ != 2'd0);
   assign m_if.m_sop   = buf_q[rd_ptr][9];
   assign m_if.m_eop   = buf_q[rd_ptr][8];
   assign m_if.m_data  = buf_q[rd_ptr][7:0];
   assign aerr_w       = (hdr_addr != 2'(PORT_ID));

   // A beat leaving this cycle frees its slot for a read issued this cycle, which keeps 1 byte/cycle.
   always_comb begin
      pop        = m_if.m_valid && m_if.m_ready;
      credit_use = {1'b0, occ} - {2'b0, pop} + {2'b0, inflight};
      owed       = (state == IDLE) || (state == HDR) ||
                   (((state == PAYLOAD) || (state == PARITY)) && (reads_left != 7'd0));
      read_enb   = !reset && vld_out && owed && (credit_use < 3'd2);
      push_sop   = (state == HDR);
      push_eop   = 1'b0;
      case (state)
         HDR:     push_eop = STRIP && (dout[7:2] == 6'd0);
         PAYLOAD: push_eop = STRIP && (rem == 6'd1);
         PARITY:  push_eop = 1'b1;
         default: push_eop = 1'b0;
      endcase
      push = inflight && !(STRIP && (state == PARITY));
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         occ      <= 2'd0;
         rd_ptr   <= 1'b0;
         wr_ptr   <= 1'b0;
         buf_q[0] <= '0;
         buf_q[1] <= '0;
      end else begin
         if (push) begin
            buf_q[wr_ptr] <= {push_sop, push_eop, dout};
            wr_ptr        <= !wr_ptr;
         end
         if (pop)
            rd_ptr <= !rd_ptr;
         occ <= occ + {1'b0, push} - {1'b0, pop};
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         inflight   <= 1'b0;
         acc        <= '0;
         rem        <= '0;
         reads_left <= '0;
         hdr_addr   <= '0;
         stall_cnt  <= '0;
         pkt_done   <= 1'b0;
         pkt_err    <= 1'b0;
         addr_err   <= 1'b0;
         abort      <= 1'b0;
         pkt_count  <= '0;
         err_count  <= '0;
      end else begin
         inflight <= read_enb;
         pkt_done <= 1'b0;
         pkt_err  <= 1'b0;
         addr_err <= 1'b0;
         abort    <= 1'b0;
         case (state)
            IDLE: begin
               stall_cnt <= '0;
               if (read_enb)
                  state <= HDR;
            end
            HDR: begin
               // Header is always returning here: the IDLE read moved us into this state.
               acc        <= dout;
               rem        <= dout[7:2];
               hdr_addr   <= dout[1:0];
               reads_left <= {1'b0, dout[7:2]} + 7'd1 - {6'd0, read_enb};
               stall_cnt  <= '0;
               state      <= (dout[7:2] != 6'd0) ? PAYLOAD : PARITY;
            end
            PAYLOAD, PARITY: begin
               if (read_enb)
                  reads_left <= reads_left - 7'd1;
               if (inflight) begin
                  stall_cnt <= '0;
                  if (state == PAYLOAD) begin
                     acc <= acc ^ dout;
                     rem <= rem - 6'd1;
                     if (rem == 6'd1)
                        state <= PARITY;
                  end else begin
                     pkt_done  <= 1'b1;
                     pkt_err   <= (acc != dout);
                     addr_err  <= aerr_w;
                     pkt_count <= pkt_count + CNT_W'(1);
                     if ((acc != dout) || aerr_w)
                        err_count <= err_count + CNT_W'(1);
                     state <= DONE;
                  end
               end else if (!vld_out) begin
                  if (stall_cnt == SW'(STALL_MAX - 1)) begin
                     pkt_done  <= 1'b1;
                     abort     <= 1'b1;
                     addr_err  <= aerr_w;
                     pkt_count <= pkt_count + CNT_W'(1);
                     err_count <= err_count + CNT_W'(1);
                     stall_cnt <= '0;
                     state     <= IDLE;
                  end else begin
                     stall_cnt <= stall_cnt + SW'(1);
                  end
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/router_out_drain.md
Name: router_out_drain

Overview:
- Consumer stage for one router output port (instantiated 3x, one per dout_out_N).
- Drains the port FIFO: asserts read_enb whenever vld_out is high and downstream has room, so the router's 30-cycle unread soft-reset never fires.
- Parses packet framing (header, payload, parity), checks parity and port address, and presents bytes to the sink on a valid/ready stream with sop/eop.
- Reports per-packet status and running packet/error counts.

Parameters:
- PORT_ID, 0, expected header address (data[1:0]) for this port; mismatch flags addr_err.
- STALL_MAX, 63, idle cycles with vld_out low mid-packet before the packet is aborted.
- CNT_W, 16, width of pkt_count and err_count.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- vld_out  in  1  port FIFO not empty.
- dout  in  8  FIFO data_out; valid in the cycle after the read_enb cycle.
- read_enb  out  1  FIFO read strobe.
- m_data  out  8  output byte.
- m_valid  out  1  m_data valid.
- m_ready  in  1  sink accepts the beat when m_valid && m_ready.
- m_sop  out  1  first beat of packet (header).
- m_eop  out  1  last beat of packet.
- pkt_done  out  1  one-cycle pulse when a packet completes or aborts.
- pkt_err  out  1  parity mismatch; qualified by pkt_done.
- addr_err  out  1  header addr != PORT_ID; qualified by pkt_done.
- abort  out  1  stall timeout; qualified by pkt_done.
- pkt_count  out  CNT_W  packets completed, including aborted packets; wraps.
- err_count  out  CNT_W  packets with pkt_err, addr_err or abort; wraps.

Behaviour:
- Reset: every output is 0. FSM goes to IDLE. Output buffer is emptied. Counters and the XOR accumulator clear.
- Output buffer: 2-entry FIFO of {data, sop, eop}. m_valid = buffer not empty. Head-of-buffer is shown on m_*.
- Read credit:
  - read_enb = vld_out && (occupancy + inflight < 2) && FSM not DONE.
  - inflight = read_enb registered one cycle.
  - The byte returned on dout in the next cycle is always written into the buffer, or dropped with the parity byte under the option.
- Full-throughput requirement: with m_ready held high, one byte per cycle is sustained.
- Framing: header byte carries len = data[7:2] (0..63) and addr = data[1:0]. The packet is header + len payload bytes + parity byte, i.e. len+2 reads in total.
- FSM states:
  - IDLE: wait for vld_out. On the first read go to HDR.
  - HDR: capture the header byte. Set acc = header, rem = len, sop = 1. Go to PAYLOAD if len > 0, else PARITY.
  - PAYLOAD: each returned byte does acc ^= byte and rem -= 1. At rem = 0, go to PARITY.
  - PARITY: capture the parity byte. Set pkt_err = (acc != byte) and eop = 1. Go to DONE.
  - DONE: single cycle. Pulse pkt_done, update counters, go to IDLE. Issue no read in this cycle; packets are separated by at least 1 idle read cycle.
- Reads in HDR, PAYLOAD and PARITY are issued only for bytes still owed (counted against len+2). A read for the next packet is never issued before DONE.
- Stall:
  - A stall counter increments each cycle mid-packet with vld_out low and no data returning. It resets on any returned byte.
  - When it reaches STALL_MAX: abort = 1, pkt_err = 0, pkt_done pulse, go to IDLE.
  - No eop is generated. Bytes already buffered still drain.
- Backpressure: m_ready low only blocks reads through the credit rule. No byte is ever lost or duplicated.
- Simultaneous buffer push and pop in the same cycle keeps occupancy unchanged.
- Counters wrap at 2^CNT_W - 1 to 0.
- reset mid-packet: immediate return to IDLE. Buffered bytes are discarded. No pkt_done.

Optional Feature:
- Macro: DRAIN_PARITY_STRIP_EN.
- Defined:
  - The parity byte is checked but not pushed to the buffer.
  - m_eop marks the last payload byte, or the header if len = 0.
  - Downstream sees len+1 beats.
- Undefined: the parity byte is forwarded as the final beat with m_eop = 1, giving len+2 beats.

Test Plan:
- Packet {0x0C (len 3, addr 0), 0x11, 0x22, 0x33, parity 0x0C^0x11^0x22^0x33 = 0x0C}, PORT_ID = 0, m_ready = 1 -> 5 beats at 1 beat/cycle; sop on 0x0C, eop on parity. pkt_done with pkt_err = 0, addr_err = 0. pkt_count = 1, err_count = 0.
- Same packet with parity 0x00 -> pkt_err = 1, err_count = 1, all bytes forwarded.
- Header 0x01 (len 0, addr 1) with parity 0x01, PORT_ID = 0 -> 2 beats (sop on header, eop on parity); addr_err = 1, pkt_err = 0.
- 20-byte payload with m_ready toggling 1 cycle on / 2 off -> output byte order and count exactly match input. occupancy never exceeds 2. read_enb never high while the credit rule is violated.
- vld_out drops after 2 payload bytes of a len = 10 packet -> after 63 cycles: abort = 1 with pkt_done; next packet is parsed cleanly from IDLE.
- DRAIN_PARITY_STRIP_EN defined, first packet -> 4 beats with eop on 0x33; pkt_err = 0. Assert reset mid-payload -> m_valid = 0 next cycle, counters = 0.
